// File: rtl/pong_game_controller.sv
// rtl/pong_game_controller.sv - Pong match sequencer: serve, play, goal detection and scoring
module pong_game_controller #(
    parameter int LEFT_GOAL    = 2,
    parameter int RIGHT_GOAL   = 637,
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       frame_tick,
    input  logic [9:0] ball_pos_x,
    input  logic [7:0] ball_size_x,
    output logic       objects_reset,
    output logic       ball_enable,
    output logic       serve_dir,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic       game_over,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        POINT     = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    localparam logic [9:0]  LEFT_LIMIT  = 10'(LEFT_GOAL);
    localparam logic [10:0] RIGHT_LIMIT = 11'(RIGHT_GOAL);
    localparam logic [3:0]  WIN_LIMIT   = 4'(WIN_SCORE);
    localparam logic [7:0]  SERVE_LAST  = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0]  POINT_LAST  = 8'(POINT_FRAMES - 1);

    state_t     cur_state;
    state_t     next_state;
    logic [7:0] frame_count;
    logic [7:0] next_frame_count;
    logic [3:0] next_score_left;
    logic [3:0] next_score_right;
    logic       next_serve_dir;
    logic       start_meta;
    logic       start_sync;
    logic       start_prev;
    logic       press;
    logic [10:0] ball_right_edge;
    logic       left_goal;
    logic       right_goal;

    // Two-flop synchronizer plus one delay flop for falling-edge detection
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            start_meta <= 1'b1;
            start_sync <= 1'b1;
            start_prev <= 1'b1;
        end else begin
            start_meta <= start;
            start_sync <= start_meta;
            start_prev <= start_sync;
        end
    end

    assign press           = start_prev & ~start_sync;
    assign ball_right_edge = {1'b0, ball_pos_x} + {3'b000, ball_size_x};
    assign left_goal       = (ball_pos_x <= LEFT_LIMIT);
    assign right_goal      = (ball_right_edge >= RIGHT_LIMIT);

    // Next-state, score and frame-count decisions
    always_comb begin
        next_state       = cur_state;
        next_score_left  = score_left;
        next_score_right = score_right;
        next_serve_dir   = serve_dir;
        next_frame_count = frame_tick ? (frame_count + 8'd1) : frame_count;
        case (cur_state)
            IDLE, GAME_OVER: begin
                if (press) begin
                    next_state       = SERVE;
                    next_score_left  = 4'd0;
                    next_score_right = 4'd0;
                    next_serve_dir   = 1'b0;
                    next_frame_count = 8'd0;
                end
            end
            SERVE: begin
                if (frame_tick && (frame_count == SERVE_LAST)) begin
                    next_state = PLAY;
                end
            end
            PLAY: begin
                if (frame_tick) begin
                    if (left_goal) begin
                        next_state       = POINT;
                        next_score_right = score_right + 4'd1;
                        next_serve_dir   = 1'b1;
                        next_frame_count = 8'd0;
                    end else if (right_goal) begin
                        next_state       = POINT;
                        next_score_left  = score_left + 4'd1;
                        next_serve_dir   = 1'b0;
                        next_frame_count = 8'd0;
                    end
                end
            end
            POINT: begin
                if (frame_tick && (frame_count == POINT_LAST)) begin
                    if ((score_left == WIN_LIMIT) || (score_right == WIN_LIMIT)) begin
                        next_state = GAME_OVER;
                    end else begin
                        next_state       = SERVE;
                        next_frame_count = 8'd0;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State, scores and outputs all register together so they move on the same edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur_state     <= IDLE;
            frame_count   <= 8'd0;
            score_left    <= 4'd0;
            score_right   <= 4'd0;
            serve_dir     <= 1'b0;
            objects_reset <= 1'b0;
            ball_enable   <= 1'b0;
            game_over     <= 1'b0;
        end else begin
            cur_state     <= next_state;
            frame_count   <= next_frame_count;
            score_left    <= next_score_left;
            score_right   <= next_score_right;
            serve_dir     <= next_serve_dir;
            objects_reset <= (next_state == PLAY) || (next_state == POINT);
            ball_enable   <= (next_state == PLAY);
            game_over     <= (next_state == GAME_OVER);
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_pong_game_controller.sv
// tb/tb_pong_game_controller.sv - self-checking bench for pong_game_controller
module tb_pong_game_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b1;
    logic       frame_tick = 1'b0;
    logic [9:0] ball_pos_x = 10'd300;
    logic [7:0] ball_size_x = 8'd4;
    logic       objects_reset;
    logic       ball_enable;
    logic       serve_dir;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic       game_over;
    logic [2:0] state;

    pong_game_controller #(
        .LEFT_GOAL(2), .RIGHT_GOAL(637), .WIN_SCORE(2), .SERVE_FRAMES(3), .POINT_FRAMES(2)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .frame_tick(frame_tick),
        .ball_pos_x(ball_pos_x), .ball_size_x(ball_size_x),
        .objects_reset(objects_reset), .ball_enable(ball_enable), .serve_dir(serve_dir),
        .score_left(score_left), .score_right(score_right), .game_over(game_over), .state(state)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit checking = 1'b0;

    // Behavioural model: phase name, scores, serve direction and frames left in the phase
    int m_state = 0;
    int m_sl = 0;
    int m_sr = 0;
    int m_dir = 0;
    int m_rem = 0;
    bit samp [3] = '{1'b1, 1'b1, 1'b1};
    bit m_press;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_new_match();
        m_sl = 0; m_sr = 0; m_dir = 0; m_state = 1; m_rem = 3;
    endtask

    initial begin
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                m_state = 0; m_sl = 0; m_sr = 0; m_dir = 0; m_rem = 0;
                samp = '{1'b1, 1'b1, 1'b1};
            end else begin
                // press seen when start was low two edges ago and high three edges ago
                m_press = (samp[1] == 1'b0) && (samp[2] == 1'b1);
                samp[2] = samp[1];
                samp[1] = samp[0];
                samp[0] = start;
                if (m_state == 0 || m_state == 4) begin
                    if (m_press) model_new_match();
                end else if (m_state == 1) begin
                    if (frame_tick) begin
                        m_rem--;
                        if (m_rem == 0) m_state = 2;
                    end
                end else if (m_state == 2) begin
                    if (frame_tick) begin
                        if (int'(ball_pos_x) <= 2) begin
                            m_sr++; m_dir = 1; m_state = 3; m_rem = 2;
                        end else if (int'(ball_pos_x) + int'(ball_size_x) >= 637) begin
                            m_sl++; m_dir = 0; m_state = 3; m_rem = 2;
                        end
                    end
                end else if (m_state == 3) begin
                    if (frame_tick) begin
                        m_rem--;
                        if (m_rem == 0) begin
                            if (m_sl == 2 || m_sr == 2) m_state = 4;
                            else begin m_state = 1; m_rem = 3; end
                        end
                    end
                end
            end
        end
    end

    // Continuous comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clock);
            if (checking) begin
                chk("m_state", int'(state), m_state);
                chk("m_score_left", int'(score_left), m_sl);
                chk("m_score_right", int'(score_right), m_sr);
                chk("m_serve_dir", int'(serve_dir), m_dir);
                chk("m_objects_reset", int'(objects_reset), (m_state == 2 || m_state == 3) ? 1 : 0);
                chk("m_ball_enable", int'(ball_enable), (m_state == 2) ? 1 : 0);
                chk("m_game_over", int'(game_over), (m_state == 4) ? 1 : 0);
            end
        end
    end

    task automatic next_cycle();
        @(negedge clock);
        cyc++;
        frame_tick = (cyc % 10 == 0);
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            next_cycle();
            n++;
        end while (!frame_tick && n < 20);
        if (!frame_tick) chk("tick_timeout", 0, 1);
    endtask

    task automatic chk_all_reset(input string tag);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_score_left"}, int'(score_left), 0);
        chk({tag, "_score_right"}, int'(score_right), 0);
        chk({tag, "_serve_dir"}, int'(serve_dir), 0);
        chk({tag, "_objects_reset"}, int'(objects_reset), 0);
        chk({tag, "_ball_enable"}, int'(ball_enable), 0);
        chk({tag, "_game_over"}, int'(game_over), 0);
    endtask

    initial begin
        int r;
        #1 reset = 1'b0;
        #1 chk_all_reset("reset_init");
        checking = 1'b1;
        repeat (2) next_cycle();
        reset = 1'b1;
        repeat (3) next_cycle();

        // Start and serve, aligned to a tick so later tick counts are known
        wait_tick();
        start = 1'b0;
        next_cycle();
        next_cycle();
        chk("start_not_yet", int'(state), 0);
        next_cycle();
        chk("start_serve", int'(state), 1);
        repeat (2) next_cycle();
        start = 1'b1;
        repeat (3) wait_tick();
        next_cycle();
        chk("serve_play_state", int'(state), 2);
        chk("serve_play_oreset", int'(objects_reset), 1);
        chk("serve_play_enable", int'(ball_enable), 1);

        // Left goal
        wait_tick();
        ball_pos_x = 10'd2; ball_size_x = 8'd4;
        next_cycle();
        ball_pos_x = 10'd300;
        chk("lgoal_score_right", int'(score_right), 1);
        chk("lgoal_dir", int'(serve_dir), 1);
        chk("lgoal_state", int'(state), 3);
        chk("lgoal_enable", int'(ball_enable), 0);
        repeat (2) wait_tick();
        next_cycle();
        chk("point_to_serve", int'(state), 1);

        // Right goal edges
        repeat (3) wait_tick();
        next_cycle();
        chk("play_again", int'(state), 2);
        wait_tick();
        ball_pos_x = 10'd632;
        next_cycle();
        chk("rgoal_miss_state", int'(state), 2);
        chk("rgoal_miss_score", int'(score_left), 0);
        ball_pos_x = 10'd700;
        next_cycle();
        chk("notick_state", int'(state), 2);
        chk("notick_score_left", int'(score_left), 0);
        chk("notick_score_right", int'(score_right), 1);
        ball_pos_x = 10'd300;
        wait_tick();
        ball_pos_x = 10'd633;
        next_cycle();
        ball_pos_x = 10'd300;
        chk("rgoal_score_left", int'(score_left), 1);
        chk("rgoal_dir", int'(serve_dir), 0);
        chk("rgoal_state", int'(state), 3);

        // Win
        repeat (2) wait_tick();
        next_cycle();
        chk("win_serve", int'(state), 1);
        repeat (3) wait_tick();
        next_cycle();
        wait_tick();
        ball_pos_x = 10'd640;
        next_cycle();
        ball_pos_x = 10'd300;
        chk("win_score_left", int'(score_left), 2);
        repeat (2) wait_tick();
        next_cycle();
        chk("gameover_state", int'(state), 4);
        chk("gameover_flag", int'(game_over), 1);
        chk("gameover_oreset", int'(objects_reset), 0);
        start = 1'b0;
        repeat (3) next_cycle();
        chk("restart_state", int'(state), 1);
        chk("restart_score_left", int'(score_left), 0);
        chk("restart_score_right", int'(score_right), 0);
        repeat (2) next_cycle();
        start = 1'b1;

        // Ignored press in PLAY, then reset mid-POINT
        repeat (3) wait_tick();
        next_cycle();
        chk("play3_state", int'(state), 2);
        start = 1'b0;
        repeat (5) next_cycle();
        start = 1'b1;
        repeat (3) next_cycle();
        chk("ignored_press", int'(state), 2);
        wait_tick();
        ball_pos_x = 10'd0;
        next_cycle();
        ball_pos_x = 10'd300;
        chk("point_before_reset", int'(state), 3);
        @(posedge clock);
        #3 reset = 1'b0;
        #1 chk_all_reset("reset_mid");
        repeat (2) next_cycle();
        reset = 1'b1;

        // Randomized play against the model
        for (int i = 0; i < 4000; i++) begin
            next_cycle();
            if ($urandom_range(0, 99) < 4) start = ~start;
            r = $urandom_range(0, 99);
            if (r < 8) ball_pos_x = 10'($urandom_range(0, 5));
            else if (r < 16) ball_pos_x = 10'($urandom_range(620, 645));
            else ball_pos_x = 10'($urandom_range(50, 550));
            ball_size_x = 8'($urandom_range(1, 20));
            if (!reset && $urandom_range(0, 3) == 0) reset = 1'b1;
            else if (reset && $urandom_range(0, 999) == 0) #2 reset = 1'b0;
        end
        reset = 1'b1;
        repeat (2) next_cycle();
        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
